// File: rtl/pb_event_ctrl_pkg.sv
// Shared constants for the LCD pushbutton front end.
// Holds the 50 MHz board defaults for the sample prescaler and the debounce depth,
// the button index assignments used by the LCD command sequencer, and an ev_id width helper.
package pb_event_ctrl_pkg;

  localparam int unsigned DefNumPb   = 4;
  localparam int unsigned DefTickDiv = 500000;  // 10 ms sample tick at 50 MHz
  localparam int unsigned DefDbCount = 4;
  localparam int unsigned DefIdW     = 2;

  // Button positions on the pb bus.
  typedef enum logic [1:0] {
    PbUp   = 2'd0,
    PbDown = 2'd1,
    PbSel  = 2'd2,
    PbBack = 2'd3
  } pb_idx_e;

  // ev_id width for a given button count (never below one bit).
  function automatic int unsigned id_width(input int unsigned num_pb);
    return (num_pb <= 2) ? 1 : $clog2(num_pb);
  endfunction

endpackage

// File: rtl/pb_event_ctrl_filter.sv
// One-button synchroniser and debouncer.
// The raw pin passes two flops; the second flop's output is sampled on each tick. A new level
// is accepted only after DbCount consecutive tick samples disagree with the current level.
// Ports:
//   clk_i     system clock
//   rst_i     synchronous reset, active-high
//   tick_i    one-cycle sample strobe
//   pb_raw_i  asynchronous button pin, active-high
//   level_o   debounced level
//   rise_o    one-cycle pulse, high during the first cycle level_o reads 1
module pb_event_ctrl_filter #(
  parameter int unsigned DbCount = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic pb_raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned CntW = (DbCount > 1) ? $clog2(DbCount) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DbCount - 1);

  logic [1:0]      sync_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rise_q, rise_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    if (tick_i) begin
      if (sync_q[1] == level_q) begin
        // Any agreeing sample restarts the streak, so short glitches never accumulate.
        cnt_d = '0;
      end else if (cnt_q == CntMax) begin
        level_d = ~level_q;
        cnt_d   = '0;
        rise_d  = ~level_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], pb_raw_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/pb_event_ctrl.sv
// Pushbutton event controller for the LCD board.
// Generates the debounce sample tick, debounces every button, latches presses as pending
// flags and hands them one at a time, round-robin, to a valid/ready consumer.
// Ports:
//   clk_i          system clock
//   rst_i          synchronous reset, active-high
//   pb_i           raw buttons, active-high
//   pb_state_o     debounced button levels
//   ev_valid_o     press event available
//   ev_id_o        index of the pressed button, held until accepted
//   ev_ready_i     consumer takes the event when ev_valid_o && ev_ready_i
//   overrun_o      sticky per button: press arrived while its event was still pending
//   clr_overrun_i  clears all overrun bits
module pb_event_ctrl import pb_event_ctrl_pkg::*; #(
  parameter int unsigned NumPb   = DefNumPb,
  parameter int unsigned TickDiv = DefTickDiv,
  parameter int unsigned DbCount = DefDbCount,
  parameter int unsigned IdW     = DefIdW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NumPb-1:0] pb_i,
  output logic [NumPb-1:0] pb_state_o,
  output logic             ev_valid_o,
  output logic [IdW-1:0]   ev_id_o,
  input  logic             ev_ready_i,
  output logic [NumPb-1:0] overrun_o,
  input  logic             clr_overrun_i
);

  localparam int unsigned PreW = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TickDiv - 1);
  localparam logic [IdW-1:0]  IdMax  = IdW'(NumPb - 1);

  // Sample tick prescaler
  logic [PreW-1:0] presc_q, presc_d;
  logic            tick;

  assign tick    = (presc_q == PreMax);
  assign presc_d = tick ? '0 : presc_q + PreW'(1);

  // Per-button debounce
  logic [NumPb-1:0] level;
  logic [NumPb-1:0] rise;

  for (genvar g = 0; g < NumPb; g++) begin : gen_filter
    pb_event_ctrl_filter #(
      .DbCount (DbCount)
    ) u_filter (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .tick_i   (tick),
      .pb_raw_i (pb_i[g]),
      .level_o  (level[g]),
      .rise_o   (rise[g])
    );
  end

  // Pending flags, overrun flags, arbiter and output register
  logic [NumPb-1:0] pending_q, pending_d;
  logic [NumPb-1:0] overrun_q, overrun_d;
  logic             valid_q, valid_d;
  logic [IdW-1:0]   id_q, id_d;
  logic [IdW-1:0]   ptr_q, ptr_d;

  logic             load;
  logic             grant_vld;
  logic [IdW-1:0]   grant_id;
  logic [NumPb-1:0] grant_mask;

  assign load = ~valid_q | ev_ready_i;

  // Round-robin: first pending index at or above the pointer, else the first below it.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int i = 0; i < int'(NumPb); i++) begin
      if (!grant_vld && pending_q[i] && (IdW'(i) >= ptr_q)) begin
        grant_vld = 1'b1;
        grant_id  = IdW'(i);
      end
    end
    for (int i = 0; i < int'(NumPb); i++) begin
      if (!grant_vld && pending_q[i]) begin
        grant_vld = 1'b1;
        grant_id  = IdW'(i);
      end
    end
  end

  always_comb begin
    grant_mask = '0;
    for (int i = 0; i < int'(NumPb); i++) begin
      grant_mask[i] = load && grant_vld && (grant_id == IdW'(i));
    end
  end

  always_comb begin
    // A press landing on the cycle its old event is granted re-arms the flag instead of
    // counting as an overrun.
    pending_d = (pending_q & ~grant_mask) | rise;
    overrun_d = (clr_overrun_i ? '0 : overrun_q) | (rise & pending_q & ~grant_mask);
  end

  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (load) begin
      if (grant_vld) begin
        valid_d = 1'b1;
        id_d    = grant_id;
        ptr_d   = (grant_id == IdMax) ? '0 : grant_id + IdW'(1);
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q   <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      ptr_q     <= '0;
    end else begin
      presc_q   <= presc_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
    end
  end

  assign pb_state_o = level;
  assign ev_valid_o = valid_q;
  assign ev_id_o    = id_q;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_pb_event_ctrl.sv
module tb_pb_event_ctrl;
  import pb_event_ctrl_pkg::*;

  localparam int NPB = 4;
  localparam int TDIV = 4;
  localparam int DBC = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [NPB-1:0] pb;
  logic [NPB-1:0] pb_state;
  logic           ev_valid;
  logic [1:0]     ev_id;
  logic           ready;
  logic [NPB-1:0] overrun;
  logic           clr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pb_event_ctrl #(
    .NumPb   (NPB),
    .TickDiv (TDIV),
    .DbCount (DBC),
    .IdW     (2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pb_i          (pb),
    .pb_state_o    (pb_state),
    .ev_valid_o    (ev_valid),
    .ev_id_o       (ev_id),
    .ev_ready_i    (ready),
    .overrun_o     (overrun),
    .clr_overrun_i (clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: clock count since reset gives the tick; each button tracks how many
  // consecutive tick samples disagreed with its accepted level; presses are a set of
  // pending buttons served in rotating order.
  int       m_pre;
  bit [3:0] m_s1, m_s2, m_st, m_stp, m_pend, m_ovr;
  int       m_streak [NPB];
  bit       m_v;
  int       m_id, m_ptr;
  bit       m_init = 1'b0;
  bit       m_tick, m_take;
  bit [3:0] m_press, m_stn, m_gm;
  int       m_g;

  always @(posedge clk) begin
    if (rst) begin
      m_pre = 0; m_s1 = 0; m_s2 = 0; m_st = 0; m_stp = 0; m_pend = 0; m_ovr = 0;
      for (int b = 0; b < NPB; b++) m_streak[b] = 0;
      m_v = 0; m_id = 0; m_ptr = 0; m_init = 1'b1;
    end else begin
      m_tick  = ((m_pre % TDIV) == TDIV - 1);
      m_pre   = m_pre + 1;
      m_press = m_st & ~m_stp;
      m_stp   = m_st;
      m_stn   = m_st;
      if (m_tick) begin
        for (int b = 0; b < NPB; b++) begin
          if (m_s2[b] != m_st[b]) begin
            m_streak[b] = m_streak[b] + 1;
            if (m_streak[b] == DBC) begin
              m_stn[b] = ~m_st[b];
              m_streak[b] = 0;
            end
          end else begin
            m_streak[b] = 0;
          end
        end
      end
      m_take = !m_v || ready;
      m_gm = 0;
      if (m_take) begin
        m_g = -1;
        for (int k = 0; k < NPB; k++)
          if (m_g < 0 && m_pend[(m_ptr + k) % NPB]) m_g = (m_ptr + k) % NPB;
        if (m_g >= 0) begin
          m_v = 1; m_id = m_g; m_ptr = (m_g + 1) % NPB; m_gm[m_g] = 1'b1;
        end else begin
          m_v = 0;
        end
      end
      m_ovr  = (clr ? 4'b0 : m_ovr) | (m_press & m_pend & ~m_gm);
      m_pend = (m_pend & ~m_gm) | m_press;
      m_st   = m_stn;
      m_s2   = m_s1;
      m_s1   = pb;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("cyc_pb_state", 32'(pb_state), 32'(m_st));
      check("cyc_ev_valid", 32'(ev_valid), 32'(m_v));
      check("cyc_ev_id", 32'(ev_id), 32'(m_id));
      check("cyc_overrun", 32'(overrun), 32'(m_ovr));
    end
  end

  // Log of events the DUT handed over (values before the edge updates them).
  int cyc = 0;
  int acc_id[$];
  int acc_cyc[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && ev_valid === 1'b1 && ready === 1'b1) begin
      acc_id.push_back(int'(ev_id));
      acc_cyc.push_back(cyc);
    end
  end

  task automatic wait_state(input logic [3:0] want, input int budget, input string name);
    int n = 0;
    while (pb_state !== want && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(pb_state), 32'(want));
  endtask

  task automatic clear_log();
    acc_id.delete();
    acc_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit found;
    rst = 1'b1; pb = '0; ready = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    // 1. Reset
    check("rst_pb_state", 32'(pb_state), 0);
    check("rst_ev_valid", 32'(ev_valid), 0);
    check("rst_ev_id", 32'(ev_id), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("idle_events", acc_id.size(), 0);
    check("idle_ev_valid", 32'(ev_valid), 0);

    // 2. Debounce: 2-tick glitch rejected, held press accepted, release silent
    pb = 4'b0010;
    repeat (8) @(negedge clk);
    pb = 4'b0000;
    repeat (20) @(negedge clk);
    check("glitch_pb_state", 32'(pb_state), 0);
    check("glitch_events", acc_id.size(), 0);
    ready = 1'b1;
    pb = 4'b0010;
    wait_state(4'b0010, 18, "press_latency");
    repeat (10) @(negedge clk);
    check("press_events", acc_id.size(), 1);
    if (acc_id.size() >= 1) check("press_id", acc_id[0], 1);
    pb = 4'b0000;
    repeat (30) @(negedge clk);
    check("release_events", acc_id.size(), 1);
    check("release_pb_state", 32'(pb_state), 0);

    // 3. Arbitration from a fresh pointer
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; ready = 1'b0; clear_log();
    pb = 4'b1011;
    wait_state(4'b1011, 20, "arb_state");
    repeat (6) @(negedge clk);
    check("arb_hold_valid", 32'(ev_valid), 1);
    check("arb_hold_id", 32'(ev_id), 0);
    repeat (3) @(negedge clk);
    check("arb_hold_id2", 32'(ev_id), 0);
    ready = 1'b1;
    repeat (5) @(negedge clk);
    check("arb_count", acc_id.size(), 3);
    if (acc_id.size() == 3) begin
      check("arb_id0", acc_id[0], 0);
      check("arb_id1", acc_id[1], 1);
      check("arb_id2", acc_id[2], 3);
      check("arb_b2b", acc_cyc[2] - acc_cyc[0], 2);
    end
    pb = 4'b0000;
    wait_state(4'b0000, 20, "arb_release");
    clear_log();
    pb = 4'b0001;
    wait_state(4'b0001, 20, "wrap_state");
    repeat (5) @(negedge clk);
    check("wrap_count", acc_id.size(), 1);
    if (acc_id.size() == 1) check("wrap_id", acc_id[0], 0);
    pb = 4'b0000;
    wait_state(4'b0000, 20, "wrap_release");

    // 4. Backpressure and overrun on PbSel
    ready = 1'b0; clear_log();
    pb = 4'b0001;
    wait_state(4'b0001, 20, "ovr_occupy");
    repeat (4) @(negedge clk);
    pb = 4'b0101;
    wait_state(4'b0101, 20, "ovr_press1");
    repeat (4) @(negedge clk);
    pb = 4'b0001;
    wait_state(4'b0001, 20, "ovr_release");
    pb = 4'b0101;
    wait_state(4'b0101, 20, "ovr_press2");
    repeat (4) @(negedge clk);
    check("ovr_flag", 32'(overrun), 32'h4);
    ready = 1'b1;
    repeat (4) @(negedge clk);
    check("ovr_count", acc_id.size(), 2);
    if (acc_id.size() == 2) begin
      check("ovr_id0", acc_id[0], 0);
      check("ovr_id1", acc_id[1], int'(PbSel));
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("ovr_clear", 32'(overrun), 0);
    pb = 4'b0000;
    wait_state(4'b0000, 20, "ovr_idle");

    // 5. New press on PbBack lands on the cycle its pending event is granted
    ready = 1'b0; clear_log();
    pb = 4'b0001;
    wait_state(4'b0001, 20, "same_occupy");
    repeat (4) @(negedge clk);
    pb = 4'b1001;
    wait_state(4'b1001, 20, "same_press1");
    repeat (4) @(negedge clk);
    pb = 4'b0001;
    wait_state(4'b0001, 20, "same_release");
    pb = 4'b1001;
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      if (m_st[3] && !m_stp[3]) begin
        ready = 1'b1;
        found = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    check("same_align", 32'(found), 1);
    repeat (5) @(negedge clk);
    check("same_count", acc_id.size(), 3);
    if (acc_id.size() == 3) begin
      check("same_id0", acc_id[0], 0);
      check("same_id1", acc_id[1], 3);
      check("same_id2", acc_id[2], 3);
    end
    check("same_overrun", 32'(overrun), 0);
    pb = 4'b0000;
    wait_state(4'b0000, 20, "same_idle");

    // 6. Reset with an event in flight and two pending
    ready = 1'b0; clear_log();
    pb = 4'b0111;
    wait_state(4'b0111, 20, "rst_mid_state");
    repeat (4) @(negedge clk);
    check("rst_mid_valid", 32'(ev_valid), 1);
    rst = 1'b1; pb = 4'b0000;
    @(negedge clk);
    check("rst_mid_pb_state", 32'(pb_state), 0);
    check("rst_mid_ev_valid", 32'(ev_valid), 0);
    check("rst_mid_ev_id", 32'(ev_id), 0);
    check("rst_mid_overrun", 32'(overrun), 0);
    rst = 1'b0; ready = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_mid_stale", acc_id.size(), 0);
    check("rst_mid_idle", 32'(ev_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
